fifo_read_ctrl: RTL and testbench
=================================

Name: fifo_read_ctrl

Overview:
Read-side controller for the async FIFO; runs entirely in the read clock domain. Drives the read port (read, radrs) of dual_port_memory and maintains the read pointer and the empty flag. Publishes the Gray-coded read pointer to the write domain and synchronises the Gray-coded write pointer coming from it. Complements the write-side controller, which owns wptr_gray and the full flag.

Parameters:
ADDRESS_SIZE, 5, memory address width; FIFO depth = 2**ADDRESS_SIZE; pointers are ADDRESS_SIZE+1 bits.
AE_THRESHOLD, 4, almost-empty level in entries; used only with RD_ALMOST_EMPTY_EN.

Ports:
rclk  input  1  read-domain clock, all flops on posedge.
rrst  input  1  asynchronous active-high reset.
rinc  input  1  pop request from consumer.
wptr_gray  input  ADDRESS_SIZE+1  Gray write pointer from write domain (asynchronous to rclk).
rptr_gray  output  ADDRESS_SIZE+1  registered Gray read pointer to write domain.
read  output  1  memory read enable (to dual_port_memory.read).
radrs  output  ADDRESS_SIZE  memory read address (to dual_port_memory.radrs).
rempty  output  1  FIFO empty, registered.
rdata_valid  output  1  memory rdata holds popped word this cycle.
rcount  output  ADDRESS_SIZE+1  registered fill level as seen by read domain.
ralmost_empty  output  1  only with RD_ALMOST_EMPTY_EN.

Behaviour:
- Reset: one clock; reset is asynchronous and active-high (rclk, rrst). Asserting rrst immediately clears rbin, rptr_gray, both sync stages and rcount to 0, sets rempty=1 and clears rdata_valid. With RD_ALMOST_EMPTY_EN, ralmost_empty=1. An in-flight pop is discarded.
- Synchroniser: wptr_gray passes through 2 flops (wq1, wq2) clocked by rclk. Only wq2 is used downstream.
- Pop accept: pop = rinc & ~rempty.
  - read = pop, combinational.
  - radrs = rbin[ADDRESS_SIZE-1:0], the current pointer.
  - The memory captures the word on the same edge the pointer advances.
- Pointer update on pop: rbin_next = rbin + pop, modulo 2**(ADDRESS_SIZE+1). rgray_next = rbin_next ^ (rbin_next >> 1). Both are registered. rptr_gray is the rgray register, Gray-only, so at most 1 bit changes per edge.
- rempty: registered as (rgray_next == wq2). Popping the last entry sets rempty on the same edge, so there is no over-read.
- rdata_valid: register of pop. Asserted exactly 1 cycle after the accepting edge, aligned with rdata.
- rcount: registered gray2bin(wq2) - rbin_next, ADDRESS_SIZE+1 bits, modulo arithmetic. Range is 0..2**ADDRESS_SIZE.
- Latency: a write-pointer change reaches rempty/rcount 3 rclk edges after it is stable at the input (2 sync + 1 flag register). Pop to rdata_valid is 1 edge.
- Boundaries:
  - Pop while empty: ignored, read=0, no pointer move.
  - Wrap-around: the pointer MSB toggles each lap, and the address wraps 31->0 with no special case.
  - rinc held continuously: one pop per cycle until empty.
  - Write arriving in the same cycle as the last pop: rempty may stay 1 for one extra cycle. This is pessimistic and allowed; it is never optimistic.
  - rcount=32 (full) is legal.

Optional Feature:
RD_ALMOST_EMPTY_EN.
- Defined: ralmost_empty is registered as (rcount_next <= AE_THRESHOLD), with reset value 1.
- Undefined: the port, its logic and AE_THRESHOLD usage are omitted.
- Without the macro the other outputs behave identically.

Test Plan:
- Reset state: assert rrst mid-run with rbin=7 -> immediately rptr_gray=0, rempty=1, rdata_valid=0, rcount=0; rinc=1 during reset -> read=0.
- Empty underflow: FIFO empty, rinc=1 for 5 cycles -> read=0, radrs stays 0, rptr_gray stays 0.
- Flag latency: wptr_gray steps 0 -> 1 (Gray 000001) -> rempty falls on the 3rd rclk edge and rcount=1. Pop -> read=1, radrs=0, rempty=1 next edge, rdata_valid=1 one cycle after.
- Burst and full level: wptr_gray=Gray(32)=110000 -> rcount=32. rinc held -> 32 consecutive reads with radrs 0..31, rempty rises after the 32nd, rptr_gray=110000.
- Wrap-around: start rbin=30 with 4 entries -> radrs sequence 30,31,0,1. rbin goes 30 -> 34 (binary 100010); at each step rptr_gray changes exactly 1 bit.
- Macro on (AE_THRESHOLD=4): rcount going 6->5->4 via pops -> ralmost_empty rises when rcount=4. Refill to 5 -> ralmost_empty falls 3 edges after the wptr change.

Source files
------------

// File: rtl/fifo_read_ctrl.sv
// -----------------------------------------------------------------------------
// fifo_read_ctrl
//   Read-side controller of the asynchronous FIFO. Runs entirely in the rclk
//   domain. It drives the read port of dual_port_memory, keeps the binary and
//   Gray read pointers, and computes the empty flag and fill level. The Gray
//   read pointer goes to the write domain. The Gray write pointer comes back
//   through a two-flop synchroniser.
//
//   Optional build macro: RD_ALMOST_EMPTY_EN adds the ralmost_empty output and
//   the AE_THRESHOLD parameter.
//
// Ports
//   rclk          read-domain clock, posedge
//   rrst          asynchronous active-high reset
//   rinc          pop request from the consumer
//   wptr_gray     Gray write pointer from the write domain (async to rclk)
//   rptr_gray     registered Gray read pointer to the write domain
//   read          memory read enable (dual_port_memory.read)
//   radrs         memory read address (dual_port_memory.radrs)
//   rempty        FIFO empty, registered
//   rdata_valid   memory rdata holds the popped word this cycle
//   rcount        registered fill level as seen by the read domain
//   ralmost_empty rcount <= AE_THRESHOLD, registered (macro builds only)
//
// Handshake: rinc acts as the consumer's valid and ~rempty acts as ready. A
// word is popped on each rising rclk edge where both are high. read shows that
// pop combinationally, and rdata_valid marks the returned word one edge later.
// -----------------------------------------------------------------------------
module fifo_read_ctrl #(
  parameter int ADDRESS_SIZE = 5
`ifdef RD_ALMOST_EMPTY_EN
  ,parameter int AE_THRESHOLD = 4
`endif
) (
  input  logic                    rclk,
  input  logic                    rrst,
  input  logic                    rinc,
  input  logic [ADDRESS_SIZE:0]   wptr_gray,
  output logic [ADDRESS_SIZE:0]   rptr_gray,
  output logic                    read,
  output logic [ADDRESS_SIZE-1:0] radrs,
  output logic                    rempty,
  output logic                    rdata_valid,
  output logic [ADDRESS_SIZE:0]   rcount
`ifdef RD_ALMOST_EMPTY_EN
  ,output logic                   ralmost_empty
`endif
);

  localparam int PW = ADDRESS_SIZE + 1;

  logic [ADDRESS_SIZE:0] rbin;
  logic [ADDRESS_SIZE:0] rbin_next;
  logic [ADDRESS_SIZE:0] rgray_next;
  logic [ADDRESS_SIZE:0] wq1;
  logic [ADDRESS_SIZE:0] wq2;
  logic [ADDRESS_SIZE:0] wq2_bin;
  logic [ADDRESS_SIZE:0] rcount_next;
  logic                  pop;

  function automatic logic [ADDRESS_SIZE:0] gray2bin(input logic [ADDRESS_SIZE:0] g);
    logic [ADDRESS_SIZE:0] b;
    b = '0;
    b[ADDRESS_SIZE] = g[ADDRESS_SIZE];
    for (int i = ADDRESS_SIZE - 1; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

  always_comb begin
    pop         = rinc & ~rempty;
    read        = pop;
    radrs       = rbin[ADDRESS_SIZE-1:0];
    rbin_next   = rbin + PW'(pop);
    rgray_next  = rbin_next ^ (rbin_next >> 1);
    wq2_bin     = gray2bin(wq2);
    // The modulo subtraction gives 0..2**ADDRESS_SIZE because the write side
    // never runs more than one depth ahead.
    rcount_next = wq2_bin - rbin_next;
  end

  // Two-flop synchroniser. Only wq2 feeds any logic.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      wq1 <= '0;
      wq2 <= '0;
    end else begin
      wq1 <= wptr_gray;
      wq2 <= wq1;
    end
  end

  // rempty is computed from the post-pop pointer. Popping the last entry
  // therefore raises it on the same edge, and no over-read can happen.
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      rbin        <= '0;
      rptr_gray   <= '0;
      rempty      <= 1'b1;
      rdata_valid <= 1'b0;
      rcount      <= '0;
    end else begin
      rbin        <= rbin_next;
      rptr_gray   <= rgray_next;
      rempty      <= (rgray_next == wq2);
      rdata_valid <= pop;
      rcount      <= rcount_next;
    end
  end

`ifdef RD_ALMOST_EMPTY_EN
  always_ff @(posedge rclk or posedge rrst) begin
    if (rrst) begin
      ralmost_empty <= 1'b1;
    end else begin
      ralmost_empty <= (rcount_next <= PW'(AE_THRESHOLD));
    end
  end
`endif

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// -----------------------------------------------------------------------------
// tb_fifo_read_ctrl
//   Bench for fifo_read_ctrl (ADDRESS_SIZE=5). The file holds:
//     - a vector table for reset, underflow and flag latency,
//     - hand sequences for burst/full, wrap-around, asynchronous reset and
//       almost-empty,
//     - randomized traffic checked against a counter-level model.
//   The model counts entries written and popped as integers. It delays the
//   write count by the three-edge visibility latency before deriving empty
//   and the fill level.
// -----------------------------------------------------------------------------
module tb_fifo_read_ctrl;

  localparam int AS = 5;
  localparam int PW = AS + 1;
  localparam int AE_THR = 4;

  // ---------------- clock / reset / DUT ----------------
  logic          rclk = 1'b0;
  logic          rrst;
  logic          rinc;
  logic [PW-1:0] wptr_gray;
  logic [PW-1:0] rptr_gray;
  logic          read;
  logic [AS-1:0] radrs;
  logic          rempty;
  logic          rdata_valid;
  logic [PW-1:0] rcount;
`ifdef RD_ALMOST_EMPTY_EN
  logic          ralmost_empty;
`endif

  always #5 rclk = ~rclk;

  fifo_read_ctrl #(
    .ADDRESS_SIZE(AS)
`ifdef RD_ALMOST_EMPTY_EN
    ,.AE_THRESHOLD(AE_THR)
`endif
  ) dut (
    .rclk       (rclk),
    .rrst       (rrst),
    .rinc       (rinc),
    .wptr_gray  (wptr_gray),
    .rptr_gray  (rptr_gray),
    .read       (read),
    .radrs      (radrs),
    .rempty     (rempty),
    .rdata_valid(rdata_valid),
    .rcount     (rcount)
`ifdef RD_ALMOST_EMPTY_EN
    ,.ralmost_empty(ralmost_empty)
`endif
  );

  // ---------------- scoreboard counters ----------------
  int n_vec  = 0;
  int n_miss = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_miss++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic logic [PW-1:0] bin2gray(input logic [PW-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // ---------------- reference model ----------------
  int   m_rd;      // entries popped, mod 64
  int   m_w;       // entries written, mod 64 (drives wptr_gray)
  int   m_count;
  logic m_empty;
  logic m_valid;
  int   w_hist[$]; // write counts still in flight toward the read domain

  task automatic model_reset();
    m_rd    = 0;
    m_w     = 0;
    m_count = 0;
    m_empty = 1'b1;
    m_valid = 1'b0;
    w_hist.delete();
    w_hist.push_back(0);
    w_hist.push_back(0);
  endtask

  // Starts and ends at posedge+1. Applies inputs, checks the combinational
  // outputs, then crosses the edge and checks the registered outputs.
  task automatic cycle(input logic inc);
    logic pop;
    int   vis;
    rinc      = inc;
    wptr_gray = bin2gray(PW'(m_w));
    #1;
    pop = inc && !m_empty;
    chk("read", read, pop);
    chk("radrs", radrs, m_rd % 32);
    @(posedge rclk);
    #1;
    if (pop) m_rd = (m_rd + 1) % 64;
    w_hist.push_back(m_w);
    vis     = w_hist.pop_front();
    m_count = (vis - m_rd + 64) % 64;
    m_empty = (m_count == 0);
    m_valid = pop;
    chk("rempty", rempty, m_empty);
    chk("rcount", rcount, m_count);
    chk("rdata_valid", rdata_valid, m_valid);
    chk("rptr_gray", rptr_gray, bin2gray(PW'(m_rd)));
`ifdef RD_ALMOST_EMPTY_EN
    chk("ralmost_empty", ralmost_empty, m_count <= AE_THR);
`endif
  endtask

  task automatic do_reset();
    rrst      = 1'b1;
    rinc      = 1'b0;
    wptr_gray = '0;
    @(posedge rclk);
    #1;
    rrst = 1'b0;
    model_reset();
  endtask

  // ---------------- vector table ----------------
  typedef struct {
    logic inc;
    int   w;
    logic e_read;
    int   e_radrs;
    logic e_empty;
    int   e_count;
    logic e_valid;
    int   e_rptr;
  } vec_t;

  vec_t tbl[10];

  int wr_pct[4] = '{70, 30, 50, 90};
  int rd_pct[4] = '{30, 70, 50, 90};

  initial begin
    logic [PW-1:0] prev;
    int            wrap_addr[4];

    wrap_addr = '{30, 31, 0, 1};

    // Underflow: five pops while empty.
    tbl[0] = '{1'b1, 0, 1'b0, 0, 1'b1, 0, 1'b0, 0};
    tbl[1] = '{1'b1, 0, 1'b0, 0, 1'b1, 0, 1'b0, 0};
    tbl[2] = '{1'b1, 0, 1'b0, 0, 1'b1, 0, 1'b0, 0};
    tbl[3] = '{1'b1, 0, 1'b0, 0, 1'b1, 0, 1'b0, 0};
    tbl[4] = '{1'b1, 0, 1'b0, 0, 1'b1, 0, 1'b0, 0};
    // One write appears. rempty falls on the third edge.
    tbl[5] = '{1'b0, 1, 1'b0, 0, 1'b1, 0, 1'b0, 0};
    tbl[6] = '{1'b0, 1, 1'b0, 0, 1'b1, 0, 1'b0, 0};
    tbl[7] = '{1'b0, 1, 1'b0, 0, 1'b0, 1, 1'b0, 0};
    // Pop the entry. Empty returns on the same edge, and data is valid after it.
    tbl[8] = '{1'b1, 1, 1'b1, 0, 1'b1, 0, 1'b1, 1};
    tbl[9] = '{1'b0, 1, 1'b0, 1, 1'b1, 0, 1'b0, 1};

    rrst      = 1'b1;
    rinc      = 1'b0;
    wptr_gray = '0;
    #1;
    chk("reset_rempty", rempty, 1);
    chk("reset_rptr", rptr_gray, 0);
    chk("reset_rcount", rcount, 0);
    chk("reset_valid", rdata_valid, 0);
    @(posedge rclk);
    @(posedge rclk);
    #1;
    rrst = 1'b0;

    for (int i = 0; i < 10; i++) begin
      rinc      = tbl[i].inc;
      wptr_gray = bin2gray(PW'(tbl[i].w));
      #1;
      chk("tbl_read", read, tbl[i].e_read);
      chk("tbl_radrs", radrs, tbl[i].e_radrs);
      @(posedge rclk);
      #1;
      chk("tbl_rempty", rempty, tbl[i].e_empty);
      chk("tbl_rcount", rcount, tbl[i].e_count);
      chk("tbl_valid", rdata_valid, tbl[i].e_valid);
      chk("tbl_rptr", rptr_gray, tbl[i].e_rptr);
    end

    // Burst to the full level, then drain continuously.
    do_reset();
    m_w = 32;
    for (int i = 0; i < 3; i++) cycle(1'b0);
    chk("burst_count32", rcount, 32);
    for (int i = 0; i < 32; i++) begin
      chk("burst_radrs", radrs, i);
      cycle(1'b1);
    end
    chk("burst_rempty", rempty, 1);
    chk("burst_rptr", rptr_gray, 6'b110000);
    cycle(1'b1);
    chk("burst_no_overread", rdata_valid, 0);

    // Wrap-around: pointer 30 -> 34 with single-bit Gray steps.
    do_reset();
    m_w = 30;
    for (int i = 0; i < 3; i++) cycle(1'b0);
    for (int i = 0; i < 30; i++) cycle(1'b1);
    m_w = 34;
    for (int i = 0; i < 3; i++) cycle(1'b0);
    for (int i = 0; i < 4; i++) begin
      chk("wrap_radrs", radrs, wrap_addr[i]);
      prev = rptr_gray;
      cycle(1'b1);
      chk("wrap_gray_step", $countones(rptr_gray ^ prev), 1);
    end
    chk("wrap_rptr", rptr_gray, 6'b110011);
    chk("wrap_rempty", rempty, 1);

    // Asynchronous reset mid-run with the pointer at 7.
    do_reset();
    m_w = 10;
    for (int i = 0; i < 3; i++) cycle(1'b0);
    for (int i = 0; i < 7; i++) cycle(1'b1);
    chk("pre_reset_rptr", rptr_gray, bin2gray(6'd7));
    rinc = 1'b1;
    #2;
    rrst      = 1'b1;
    wptr_gray = '0;
    #1;
    chk("async_rptr", rptr_gray, 0);
    chk("async_rempty", rempty, 1);
    chk("async_valid", rdata_valid, 0);
    chk("async_rcount", rcount, 0);
    chk("async_read", read, 0);
    chk("async_radrs", radrs, 0);
`ifdef RD_ALMOST_EMPTY_EN
    chk("async_ae", ralmost_empty, 1);
`endif
    @(posedge rclk);
    #1;
    rrst = 1'b0;
    model_reset();

`ifdef RD_ALMOST_EMPTY_EN
    // Almost-empty threshold crossing in both directions.
    do_reset();
    m_w = 6;
    for (int i = 0; i < 3; i++) cycle(1'b0);
    chk("ae_at6", ralmost_empty, 0);
    cycle(1'b1);
    chk("ae_at5", ralmost_empty, 0);
    cycle(1'b1);
    chk("ae_at4", ralmost_empty, 1);
    m_w = 7;
    cycle(1'b0);
    chk("ae_refill_e1", ralmost_empty, 1);
    cycle(1'b0);
    chk("ae_refill_e2", ralmost_empty, 1);
    cycle(1'b0);
    chk("ae_refill_e3", ralmost_empty, 0);
`endif

    // Randomized traffic. The writer never runs more than one depth ahead.
    do_reset();
    for (int p = 0; p < 4; p++) begin
      for (int i = 0; i < 700; i++) begin
        if (((m_w - m_rd + 64) % 64) < 32 && $urandom_range(0, 99) < wr_pct[p])
          m_w = (m_w + 1) % 64;
        cycle($urandom_range(0, 99) < rd_pct[p]);
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
